// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet input feeder: FSM encoding and sizing helpers.
package lenet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    WAIT_L1,
    WAIT_RES,
    NEXT
  } state_t;

  localparam int DEF_IMG_W   = 28;
  localparam int DEF_IMG_H   = 28;
  localparam int PIX_PER_IMG = DEF_IMG_W * DEF_IMG_H;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((longint'(1) << i) < longint'(n)) r = i + 1;
    return r;
  endfunction

  function automatic int pix_per_img(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/image_feeder_valid_delay.sv
// Fixed-depth delay line aligning the address-issue flag with ROM read data.
module valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic flag,
  output logic delayed
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      sr <= '0;
    end else begin
      sr[0] <= flag;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign delayed = sr[DEPTH-1];

endmodule

// File: rtl/image_feeder.sv
// Streams images out of the input ROM pixel by pixel and collects one
// classification result per image from the network.
module image_feeder
  import lenet_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int NUM_IMAGES = 16,
  parameter int ADDR_W     = 14,
  parameter int ROM_LAT    = 1,
  parameter int LOOP       = 0,
  localparam int IDX_W =
    (clog2(NUM_IMAGES) < 1) ? 1 : clog2(NUM_IMAGES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              map_valid,
  input  logic              layer1_finish,
  input  logic              finish,
  input  logic [3:0]        index,
  output logic [IDX_W-1:0]  img_idx,
  output logic [3:0]        result_idx,
  output logic              result_valid,
  output logic              busy,
  output logic              done
);

  localparam int PIX = pix_per_img(IMG_W, IMG_H);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(PIX - 1);
  localparam logic [ADDR_W-1:0] PIX_STEP = ADDR_W'(PIX);
  localparam logic [IDX_W-1:0]  IMG_LAST = IDX_W'(NUM_IMAGES - 1);

  if (longint'(NUM_IMAGES) * IMG_W * IMG_H > (longint'(1) << ADDR_W))
  begin : g_rom_too_small
    $error("image_feeder: images do not fit in ADDR_W address space");
  end

  if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_bad_lat
    $error("image_feeder: ROM_LAT must be 1..4");
  end

  state_t state, state_nxt;

  logic [ADDR_W-1:0] pix;
  logic [ADDR_W-1:0] base;
  logic              l1_seen;
  logic              res_got;

  logic run_init;
  logic img_adv;
  logic pix_inc;
  logic capture;
  logic l1_set;
  logic l1_clr;
  logic done_set;
  logic finish_ok;

  assign finish_ok = finish && !res_got;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run_init  = 1'b0;
    img_adv   = 1'b0;
    pix_inc   = 1'b0;
    capture   = 1'b0;
    l1_set    = 1'b0;
    l1_clr    = 1'b0;
    done_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = STREAM;
          run_init  = 1'b1;
        end
      end
      STREAM: begin
        capture = finish_ok;
        if (pix == PIX_LAST) begin
          // A consumption pulse seen early skips the wait entirely.
          state_nxt = (l1_seen || layer1_finish) ? WAIT_RES : WAIT_L1;
          l1_clr    = 1'b1;
        end else begin
          pix_inc = 1'b1;
          l1_set  = layer1_finish;
        end
      end
      WAIT_L1: begin
        capture = finish_ok;
        if (layer1_finish || l1_seen) begin
          state_nxt = WAIT_RES;
          l1_clr    = 1'b1;
        end
      end
      WAIT_RES: begin
        capture = finish_ok;
        if (res_got || finish) state_nxt = NEXT;
      end
      NEXT: begin
        if (img_idx != IMG_LAST) begin
          img_adv   = 1'b1;
          state_nxt = STREAM;
        end else if (LOOP != 0) begin
          run_init  = 1'b1;
          state_nxt = STREAM;
        end else begin
          done_set  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      run_init  = 1'b0;
      img_adv   = 1'b0;
      pix_inc   = 1'b0;
      capture   = 1'b0;
      l1_set    = 1'b0;
      l1_clr    = 1'b1;
      done_set  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix          <= '0;
      base         <= '0;
      img_idx      <= '0;
      l1_seen      <= 1'b0;
      res_got      <= 1'b0;
      result_idx   <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      result_valid <= capture;
      done         <= done_set;
      if (capture) begin
        result_idx <= index;
        res_got    <= 1'b1;
      end
      if (pix_inc) pix <= pix + 1'b1;
      if (l1_set)  l1_seen <= 1'b1;
      if (l1_clr)  l1_seen <= 1'b0;
      if (run_init) begin
        pix     <= '0;
        base    <= '0;
        img_idx <= '0;
        res_got <= 1'b0;
      end
      if (img_adv) begin
        pix     <= '0;
        base    <= base + PIX_STEP;
        img_idx <= img_idx + 1'b1;
        res_got <= 1'b0;
      end
      if (abort) res_got <= 1'b0;
    end
  end

  assign rom_addr = base + pix;
  assign busy     = (state != IDLE);

  valid_delay #(
    .DEPTH (ROM_LAT)
  ) u_valid_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (abort),
    .flag    (state == STREAM),
    .delayed (map_valid)
  );

endmodule
